lb_mailbox: RTL and testbench

Local-bus slave that sits directly downstream of the Mesa Bus backdoor interface and consumes its 32-bit `lb_wr`/`lb_rd` transactions. It provides a host-to-user FIFO (h2u), a user-to-host FIFO (u2h), status/control registers and a scratch register, so PC software can stream words to and from user logic. It returns read data through the pipelined `lb_rd_rdy` handshake, and its `lb_rd_d` is zero when idle so it can be OR-muxed with other slaves.

---
 rtl/lb_mailbox_if.sv | 30 +++
 rtl/lb_mailbox.sv | 163 ++++++++++++++++
 tb/tb_lb_mailbox.sv | 578 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_mailbox_if.sv
// lb_mailbox_if: local-bus strobes, read return and the
// user-side h2u/u2h stream handshakes of the mailbox.
interface lb_mailbox_if;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport slave (
    input  lb_wr, lb_rd, lb_addr, lb_wr_d,
    input  out_ready, in_valid, in_data,
    output lb_rd_d, lb_rd_rdy,
    output out_valid, out_data, in_ready
  );

  modport master (
    output lb_wr, lb_rd, lb_addr, lb_wr_d,
    output out_ready, in_valid, in_data,
    input  lb_rd_d, lb_rd_rdy,
    input  out_valid, out_data, in_ready
  );
endinterface

// File: rtl/lb_mailbox.sv
// lb_mailbox: local-bus mailbox slave with host<->user FIFOs,
// status/control and scratch; two-stage pipelined read return.
module lb_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          DEPTH     = 16,
  parameter int          CW        = 9
) (
  input logic         clk_lb,
  input logic         reset_l,
  lb_mailbox_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   h_mem [DEPTH];
  logic [31:0]   u_mem [DEPTH];
  logic [AW-1:0] h_wp, h_rp, u_wp, u_rp;
  logic [CW-1:0] h_cnt, u_cnt;
  logic          ovf, udf;
  logic [31:0]   scratch;
  logic          rd_v1, rd_v2;
  logic [31:0]   rd_d1, rd_d2;

  logic          hit, hit_wr, hit_rd;
  logic [2:0]    off;
  logic          h_full, h_empty, u_full, u_empty;
  logic          h_flush, u_flush, clr;
  logic          h_push_req, h_push, h_pop, h_ovf_ev;
  logic          u_pop_req, u_push, u_pop, u_udf_ev;
  logic [31:0]   status, rd_mux;
  logic          unused_ok;

  assign hit    = bus.lb_addr[31:5] == BASE_ADDR[31:5];
  assign hit_wr = bus.lb_wr && hit;
  assign hit_rd = bus.lb_rd && hit;
  assign off    = bus.lb_addr[4:2];
  assign unused_ok = ^bus.lb_addr[1:0];

  assign h_full  = h_cnt == FULL_CNT;
  assign h_empty = h_cnt == '0;
  assign u_full  = u_cnt == FULL_CNT;
  assign u_empty = u_cnt == '0;

  assign h_flush = hit_wr && off == 3'd0 && bus.lb_wr_d[0];
  assign u_flush = hit_wr && off == 3'd0 && bus.lb_wr_d[1];
  assign clr     = hit_wr && off == 3'd0 && bus.lb_wr_d[2];

  // a full h2u still accepts a word if the user pops it free
  assign h_push_req = hit_wr && off == 3'd2;
  assign h_pop      = bus.out_ready && !h_empty && !h_flush;
  assign h_push     = h_push_req && !h_flush &&
                      (!h_full || h_pop);
  assign h_ovf_ev   = h_push_req && !h_flush &&
                      h_full && !h_pop;

  // host pop of an empty u2h is an underflow, never a pop
  assign u_pop_req = hit_rd && off == 3'd3;
  assign u_pop     = u_pop_req && !u_empty && !u_flush;
  assign u_udf_ev  = u_pop_req && u_empty && !u_flush;
  assign u_push    = bus.in_valid && !u_full && !u_flush;

  assign bus.out_valid = !h_empty;
  assign bus.out_data  = h_empty ? '0 : h_mem[h_rp];
  assign bus.in_ready  = !u_full;
  assign bus.lb_rd_d   = rd_d2;
  assign bus.lb_rd_rdy = rd_v2;

  // status word assembly
  always_comb begin
    status = '0;
    status[CW-1:0]  = h_cnt;
    status[16 +: CW] = u_cnt;
    status[28] = ovf;
    status[29] = udf;
    status[30] = h_full;
    status[31] = u_empty;
  end

  // read data select from pre-write state
  always_comb begin
    rd_mux = '0;
    unique case (off)
      3'd1:    rd_mux = status;
      3'd3:    rd_mux = u_empty ? '0 : u_mem[u_rp];
      3'd4:    rd_mux = scratch;
      default: rd_mux = '0;
    endcase
  end

  // h2u pointers and occupancy
  always_ff @(posedge clk_lb or negedge reset_l) begin
    if (!reset_l) begin
      h_wp  <= '0;
      h_rp  <= '0;
      h_cnt <= '0;
    end else if (h_flush) begin
      h_wp  <= '0;
      h_rp  <= '0;
      h_cnt <= '0;
    end else begin
      if (h_push) h_wp <= h_wp + AW'(1);
      if (h_pop)  h_rp <= h_rp + AW'(1);
      h_cnt <= h_cnt + CW'(h_push) - CW'(h_pop);
    end
  end

  // u2h pointers and occupancy
  always_ff @(posedge clk_lb or negedge reset_l) begin
    if (!reset_l) begin
      u_wp  <= '0;
      u_rp  <= '0;
      u_cnt <= '0;
    end else if (u_flush) begin
      u_wp  <= '0;
      u_rp  <= '0;
      u_cnt <= '0;
    end else begin
      if (u_push) u_wp <= u_wp + AW'(1);
      if (u_pop)  u_rp <= u_rp + AW'(1);
      u_cnt <= u_cnt + CW'(u_push) - CW'(u_pop);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk_lb) begin
    if (h_push) h_mem[h_wp] <= bus.lb_wr_d;
    if (u_push) u_mem[u_wp] <= bus.in_data;
  end

  // sticky error flags; a new event beats a clear
  always_ff @(posedge clk_lb or negedge reset_l) begin
    if (!reset_l) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (h_ovf_ev)  ovf <= 1'b1;
      else if (clr)  ovf <= 1'b0;
      if (u_udf_ev)  udf <= 1'b1;
      else if (clr)  udf <= 1'b0;
    end
  end

  // scratch register
  always_ff @(posedge clk_lb or negedge reset_l) begin
    if (!reset_l) scratch <= '0;
    else if (hit_wr && off == 3'd4) scratch <= bus.lb_wr_d;
  end

  // read return pipeline: capture, then output register
  always_ff @(posedge clk_lb or negedge reset_l) begin
    if (!reset_l) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
      rd_v2 <= 1'b0;
      rd_d2 <= '0;
    end else begin
      rd_v1 <= hit_rd;
      rd_d1 <= hit_rd ? rd_mux : '0;
      rd_v2 <= rd_v1;
      rd_d2 <= rd_v1 ? rd_d1 : '0;
    end
  end
endmodule

// File: tb/tb_lb_mailbox.sv
// tb_lb_mailbox: randomized scenarios for lb_mailbox checked
// against a queue-based model of the mailbox registers.
module tb_lb_mailbox;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam logic [31:0] A_CTRL = 32'h0000_0100;
  localparam logic [31:0] A_STAT = 32'h0000_0104;
  localparam logic [31:0] A_H2U  = 32'h0000_0108;
  localparam logic [31:0] A_U2H  = 32'h0000_010C;
  localparam logic [31:0] A_SCR  = 32'h0000_0110;

  logic clk_lb  = 1'b0;
  logic reset_l = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  logic [31:0] hq[$];
  logic [31:0] uq[$];
  logic        m_ovf;
  logic        m_udf;
  logic [31:0] m_scr;

  lb_mailbox_if bus ();

  lb_mailbox #(
    .BASE_ADDR(32'h0000_0100),
    .DEPTH(DEPTH),
    .CW(CW)
  ) dut (
    .clk_lb(clk_lb),
    .reset_l(reset_l),
    .bus(bus)
  );

  always #5 clk_lb = ~clk_lb;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[CW-1:0]  = CW'(hq.size());
    s[16 +: CW] = CW'(uq.size());
    s[28] = m_ovf;
    s[29] = m_udf;
    s[30] = (hq.size() == DEPTH);
    s[31] = (uq.size() == 0);
    return s;
  endfunction

  task automatic idle_inputs();
    bus.lb_wr     = 1'b0;
    bus.lb_rd     = 1'b0;
    bus.lb_addr   = '0;
    bus.lb_wr_d   = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
  endtask

  task automatic model_reset();
    hq.delete();
    uq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_scr = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk_lb);
    idle_inputs();
    reset_l = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_lb);
    reset_l = 1'b1;
  endtask

  task automatic host_write(input logic [31:0] a,
                            input logic [31:0] d);
    @(negedge clk_lb);
    bus.lb_wr   = 1'b1;
    bus.lb_addr = a;
    bus.lb_wr_d = d;
    @(negedge clk_lb);
    bus.lb_wr   = 1'b0;
  endtask

  task automatic host_read(input  logic [31:0] a,
                           output logic [31:0] d,
                           output int lat);
    @(negedge clk_lb);
    bus.lb_rd   = 1'b1;
    bus.lb_addr = a;
    lat = -1;
    d   = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_lb);
      bus.lb_rd = 1'b0;
      if (bus.lb_rd_rdy === 1'b1) begin
        lat = i;
        d   = bus.lb_rd_d;
        break;
      end
    end
  endtask

  task automatic user_push(input  logic [31:0] d,
                           output logic rdy);
    @(negedge clk_lb);
    rdy = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk_lb);
    bus.in_valid = 1'b0;
  endtask

  task automatic m_h2u_write(input logic [31:0] d);
    if (hq.size() < DEPTH) hq.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    idle_inputs();
    reset_l = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_lb);
    total++;
    if (bus.lb_rd_rdy !== 1'b0 || bus.lb_rd_d !== 32'h0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_out: rdy=%b d=%h ov=%b ir=%b want 0 0 0 1",
               bus.lb_rd_rdy, bus.lb_rd_d, bus.out_valid,
               bus.in_ready);
    end
    reset_l = 1'b1;
    host_read(A_STAT, d, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL stat_latency: got %0d want 2", lat);
    end
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL stat_reset: got %h want %h", d, exp_status());
    end
    host_read(32'h0000_01F0, d, lat);
    total++;
    if (lat !== -1) begin
      bad++;
      $display("FAIL miss_read: rdy after %0d cycles want none", lat);
    end
    host_read(A_CTRL, d, lat);
    total++;
    if (lat !== 2 || d !== 32'h0) begin
      bad++;
      $display("FAIL ctrl_read: lat=%0d d=%h want 2 0", lat, d);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    logic [31:0] v;
    int lat;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      if (i == 0) v = 32'hDEAD_BEEF;
      host_write(A_SCR, v);
      m_scr = v;
      host_read(A_SCR, d, lat);
      total++;
      if (lat !== 2 || d !== m_scr) begin
        bad++;
        $display("FAIL scratch_rw: lat=%0d got %h want %h",
                 lat, d, m_scr);
      end
    end
    host_write(32'h0000_0118, $urandom);
    host_read(32'h0000_0118, d, lat);
    total++;
    if (lat !== 2 || d !== 32'h0) begin
      bad++;
      $display("FAIL reserved: lat=%0d got %h want 0", lat, d);
    end
    host_write(32'h0000_0210, $urandom);
    host_read(A_SCR, d, lat);
    total++;
    if (d !== m_scr) begin
      bad++;
      $display("FAIL miss_write: got %h want %h", d, m_scr);
    end
    apply_reset();
    host_read(A_SCR, d, lat);
    total++;
    if (d !== m_scr) begin
      bad++;
      $display("FAIL scratch_reset: got %h want %h", d, m_scr);
    end
  endtask

  task automatic test_h2u_overflow();
    logic [31:0] d;
    logic [31:0] e;
    int lat;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      host_write(A_H2U, 32'(i));
      m_h2u_write(32'(i));
    end
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL h2u_ovf_stat: got %h want %h", d, exp_status());
    end
    @(negedge clk_lb);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e = hq.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
        bad++;
        $display("FAIL h2u_drain[%0d]: ov=%b got %h want %h",
                 i, bus.out_valid, bus.out_data, e);
      end
      @(negedge clk_lb);
    end
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL h2u_empty: ov=%b want 0", bus.out_valid);
    end
    host_write(A_CTRL, 32'h4);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL ovf_clear: got %h want %h", d, exp_status());
    end
  endtask

  task automatic test_u2h();
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] w;
    logic        r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      w = 32'hA0 + 32'(i);
      user_push(w, r);
      total++;
      if (r !== (uq.size() < DEPTH)) begin
        bad++;
        $display("FAIL u2h_ready[%0d]: got %b", i, r);
      end
      if (uq.size() < DEPTH) uq.push_back(w);
    end
    for (int i = 0; i < 5; i++) begin
      host_read(A_U2H, d, lat);
      if (uq.size() == 0) begin
        e = '0;
        m_udf = 1'b1;
      end else begin
        e = uq.pop_front();
      end
      total++;
      if (lat !== 2 || d !== e) begin
        bad++;
        $display("FAIL u2h_read[%0d]: lat=%0d got %h want %h",
                 i, lat, d, e);
      end
    end
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL udf_stat: got %h want %h", d, exp_status());
    end
    for (int i = 0; i <= DEPTH; i++) begin
      w = $urandom;
      user_push(w, r);
      total++;
      if (r !== (uq.size() < DEPTH)) begin
        bad++;
        $display("FAIL u2h_fill[%0d]: in_ready=%b", i, r);
      end
      if (uq.size() < DEPTH) uq.push_back(w);
    end
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL u2h_full_stat: got %h want %h", d, exp_status());
    end
    while (uq.size() > 0) begin
      host_read(A_U2H, d, lat);
      e = uq.pop_front();
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL u2h_drain: got %h want %h", d, e);
      end
    end
    host_write(A_CTRL, 32'h4);
    m_ovf = 1'b0;
    m_udf = 1'b0;
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL udf_clear: got %h want %h", d, exp_status());
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] x;
    logic        r;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      x = $urandom;
      host_write(A_H2U, x);
      m_h2u_write(x);
    end
    x = $urandom;
    @(negedge clk_lb);
    bus.lb_wr     = 1'b1;
    bus.lb_addr   = A_H2U;
    bus.lb_wr_d   = x;
    bus.out_ready = 1'b1;
    e = hq.pop_front();
    hq.push_back(x);
    total++;
    if (bus.out_data !== e) begin
      bad++;
      $display("FAIL full_pp_head: got %h want %h", bus.out_data, e);
    end
    @(negedge clk_lb);
    bus.lb_wr     = 1'b0;
    bus.out_ready = 1'b0;
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL full_pp_stat: got %h want %h", d, exp_status());
    end
    @(negedge clk_lb);
    bus.out_ready = 1'b1;
    while (hq.size() > 0) begin
      e = hq.pop_front();
      total++;
      if (bus.out_data !== e) begin
        bad++;
        $display("FAIL full_pp_drain: got %h want %h",
                 bus.out_data, e);
      end
      @(negedge clk_lb);
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = $urandom;
      host_write(A_H2U, x);
      m_h2u_write(x);
    end
    @(negedge clk_lb);
    bus.lb_wr     = 1'b1;
    bus.lb_addr   = A_CTRL;
    bus.lb_wr_d   = 32'h1;
    bus.out_ready = 1'b1;
    hq.delete();
    @(negedge clk_lb);
    bus.lb_wr     = 1'b0;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== (hq.size() != 0)) begin
      bad++;
      $display("FAIL h2u_flush: ov=%b want 0", bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      user_push(x, r);
      uq.push_back(x);
    end
    @(negedge clk_lb);
    bus.lb_wr    = 1'b1;
    bus.lb_addr  = A_CTRL;
    bus.lb_wr_d  = 32'h2;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    uq.delete();
    @(negedge clk_lb);
    bus.lb_wr    = 1'b0;
    bus.in_valid = 1'b0;
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL u2h_flush: got %h want %h", d, exp_status());
    end
    host_read(A_U2H, d, lat);
    m_udf = 1'b1;
    host_read(A_STAT, d, lat);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL flush_udf: got %h want %h", d, exp_status());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp [4];
    logic [31:0] nv;
    nv = $urandom;
    addrs[0] = A_STAT;
    addrs[1] = A_SCR;
    addrs[2] = A_SCR;
    addrs[3] = 32'h0000_0114;
    exp[0] = exp_status();
    exp[1] = m_scr;
    exp[2] = nv;
    exp[3] = '0;
    m_scr = nv;
    @(negedge clk_lb);
    for (int j = 0; j < 7; j++) begin
      if (j < 4) begin
        bus.lb_rd   = 1'b1;
        bus.lb_addr = addrs[j];
        bus.lb_wr   = (j == 1);
        bus.lb_wr_d = nv;
      end else begin
        bus.lb_rd = 1'b0;
        bus.lb_wr = 1'b0;
      end
      total++;
      if (j >= 2 && j <= 5) begin
        if (bus.lb_rd_rdy !== 1'b1 || bus.lb_rd_d !== exp[j-2]) begin
          bad++;
          $display("FAIL b2b[%0d]: rdy=%b got %h want %h",
                   j - 2, bus.lb_rd_rdy, bus.lb_rd_d, exp[j-2]);
        end
      end else if (bus.lb_rd_rdy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle[%0d]: rdy=%b want 0",
                 j, bus.lb_rd_rdy);
      end
      @(negedge clk_lb);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] w;
    logic        r;
    int lat;
    int op;
    for (int k = 0; k < 120; k++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 5: begin
          w = $urandom;
          host_write(A_H2U, w);
          m_h2u_write(w);
        end
        1: begin
          host_read(A_U2H, d, lat);
          if (uq.size() == 0) begin
            e = '0;
            m_udf = 1'b1;
          end else begin
            e = uq.pop_front();
          end
          total++;
          if (lat !== 2 || d !== e) begin
            bad++;
            $display("FAIL rnd_u2h[%0d]: lat=%0d got %h want %h",
                     k, lat, d, e);
          end
        end
        2, 6: begin
          w = $urandom;
          user_push(w, r);
          total++;
          if (r !== (uq.size() < DEPTH)) begin
            bad++;
            $display("FAIL rnd_push[%0d]: in_ready=%b", k, r);
          end
          if (uq.size() < DEPTH) uq.push_back(w);
        end
        3: begin
          @(negedge clk_lb);
          total++;
          if (bus.out_valid !== (hq.size() != 0) ||
              (hq.size() != 0 && bus.out_data !== hq[0])) begin
            bad++;
            $display("FAIL rnd_pop[%0d]: ov=%b data=%h", k,
                     bus.out_valid, bus.out_data);
          end
          bus.out_ready = 1'b1;
          @(negedge clk_lb);
          bus.out_ready = 1'b0;
          if (hq.size() != 0) e = hq.pop_front();
        end
        default: begin
          host_read(A_STAT, d, lat);
          total++;
          if (d !== exp_status()) begin
            bad++;
            $display("FAIL rnd_stat[%0d]: got %h want %h",
                     k, d, exp_status());
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    logic        r;
    int lat;
    int seen;
    host_write(A_H2U, $urandom);
    user_push($urandom, r);
    @(negedge clk_lb);
    bus.lb_rd   = 1'b1;
    bus.lb_addr = A_STAT;
    @(negedge clk_lb);
    bus.lb_rd = 1'b0;
    reset_l   = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus.lb_rd_rdy !== 1'b0 || bus.lb_rd_d !== 32'h0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: rdy=%b d=%h ov=%b ir=%b",
               bus.lb_rd_rdy, bus.lb_rd_d, bus.out_valid,
               bus.in_ready);
    end
    repeat (2) @(negedge clk_lb);
    reset_l = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_lb);
      if (bus.lb_rd_rdy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL inflight_rdy: got %0d pulses want 0", seen);
    end
    host_read(A_STAT, d, lat);
    total++;
    if (lat !== 2 || d !== exp_status()) begin
      bad++;
      $display("FAIL post_reset_stat: lat=%0d got %h want %h",
               lat, d, exp_status());
    end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_h2u_overflow();
    test_u2h();
    test_full_push_pop();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
